// File: rtl/csa_pkg.sv
// Shared elaboration-time helpers for the pipelined carry-save adder tree:
// widths, level counts and per-level row counts.
package csa_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 32'sd0;
        v = 32'sd1;
        while (v < n) begin
            v = v * 32'sd2;
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Each full group of three rows becomes two rows; leftovers pass through.
    function automatic int rows_after(input int n);
        return (32'sd2 * (n / 32'sd3)) + (n % 32'sd3);
    endfunction

    function automatic int csa_levels(input int n);
        int l;
        int r;
        l = 32'sd0;
        r = n;
        while (r > 32'sd2) begin
            r = rows_after(r);
            l = l + 32'sd1;
        end
        return l;
    endfunction

    function automatic int rows_at(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 32'sd0; i < lvl; i++) begin
            r = rows_after(r);
        end
        return r;
    endfunction

    function automatic int out_width(input int n, input int w);
        return w + clog2(n);
    endfunction

    function automatic int res_width(input int n, input int w, input int acc_en, input int guard);
        return (acc_en != 32'sd0) ? (out_width(n, w) + guard) : out_width(n, w);
    endfunction

endpackage

// File: rtl/csa_tree_pipe_row.sv
// One 3:2 compressor row: bitwise sum plus majority carry, already shifted
// left by one and truncated to the row width.
module csa_row
    import csa_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined N-operand carry-save adder tree with a registered final add,
// valid/ready handshaking and an optional per-packet accumulator.
module csa_tree_pipe
    import csa_pkg::*;
#(
    parameter  int N_OPS     = 4,
    parameter  int WIDTH     = 4,
    parameter  int SIGNED    = 1,
    parameter  int ACC_EN    = 0,
    parameter  int ACC_GUARD = 4,
    localparam int OUT_W     = out_width(N_OPS, WIDTH),
    localparam int RES_W     = res_width(N_OPS, WIDTH, ACC_EN, ACC_GUARD)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_OPS*WIDTH-1:0] in_ops,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RES_W-1:0]       out_sum
);

    localparam int LEVELS = csa_levels(N_OPS);

    logic              stall_s;
    logic [OUT_W-1:0]  ext_s [N_OPS];
    logic [LEVELS-1:0] vld_r;
    logic [LEVELS-1:0] last_r;
    logic [OUT_W-1:0]  cpa_s;
    logic [RES_W-1:0]  cpa_ext_s;
    logic [RES_W-1:0]  total_s;
    logic [RES_W-1:0]  acc_r;
    logic              emit_s;

    // One global stall freezes every stage while the output waits.
    assign stall_s  = out_valid && !out_ready;
    assign in_ready = !stall_s;

    for (genvar k = 0; k < N_OPS; k++) begin : g_ext
        logic [WIDTH-1:0] op_s;
        assign op_s     = in_ops[k*WIDTH +: WIDTH];
        assign ext_s[k] = (SIGNED != 32'sd0) ? {{(OUT_W-WIDTH){op_s[WIDTH-1]}}, op_s}
                                             : {{(OUT_W-WIDTH){1'b0}}, op_s};
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N_IN  = rows_at(N_OPS, l);
        localparam int N_GRP = N_IN / 32'sd3;
        localparam int N_OUT = rows_after(N_IN);

        logic [OUT_W-1:0] in_s  [N_IN];
        logic [OUT_W-1:0] nxt_s [N_OUT];
        logic [OUT_W-1:0] row_r [N_OUT];

        for (genvar i = 0; i < N_IN; i++) begin : g_src
            if (l == 32'sd0) begin : g_op
                assign in_s[i] = ext_s[i];
            end else begin : g_prev
                assign in_s[i] = g_lvl[l-32'sd1].row_r[i];
            end
        end

        for (genvar g = 0; g < N_GRP; g++) begin : g_grp
            csa_row #(.W(OUT_W)) u_row (
                .a     (in_s[32'sd3*g]),
                .b     (in_s[32'sd3*g+32'sd1]),
                .c     (in_s[32'sd3*g+32'sd2]),
                .sum   (nxt_s[32'sd2*g]),
                .carry (nxt_s[32'sd2*g+32'sd1])
            );
        end

        for (genvar r = 0; r < N_IN - 32'sd3*N_GRP; r++) begin : g_pass
            assign nxt_s[32'sd2*N_GRP + r] = in_s[32'sd3*N_GRP + r];
        end

        // Level pipeline register; contents are don't-care while the stage is a bubble.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 32'sd0; i < N_OUT; i++) begin
                    row_r[i] <= '0;
                end
            end else if (!stall_s) begin
                row_r <= nxt_s;
            end
        end
    end

    // Valid and packet-end flags travel alongside their beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r  <= '0;
            last_r <= '0;
        end else if (!stall_s) begin
            for (int l = LEVELS - 32'sd1; l > 32'sd0; l--) begin
                vld_r[l]  <= vld_r[l-1];
                last_r[l] <= last_r[l-1];
            end
            vld_r[0]  <= in_valid;
            last_r[0] <= in_last;
        end
    end

    assign cpa_s = g_lvl[LEVELS-1].row_r[0] + g_lvl[LEVELS-1].row_r[1];

    if (RES_W > OUT_W) begin : g_guard
        assign cpa_ext_s = (SIGNED != 32'sd0) ? {{(RES_W-OUT_W){cpa_s[OUT_W-1]}}, cpa_s}
                                              : {{(RES_W-OUT_W){1'b0}}, cpa_s};
    end else begin : g_noguard
        assign cpa_ext_s = cpa_s;
    end

    // Without accumulation every beat is its own packet, so acc_r stays zero.
    assign emit_s  = (ACC_EN == 32'sd0) || last_r[LEVELS-1];
    assign total_s = acc_r + cpa_ext_s;

    // Final add, accumulation and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            acc_r     <= '0;
        end else if (!stall_s) begin
            if (vld_r[LEVELS-1] && emit_s) begin
                out_valid <= 1'b1;
                out_sum   <= total_s;
                acc_r     <= '0;
            end else if (vld_r[LEVELS-1]) begin
                out_valid <= 1'b0;
                acc_r     <= total_s;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/csa_tree_pipe.md
Name: csa_tree_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 4-operand combinational Wallace-tree adders.
- Sums N_OPS operands of WIDTH bits each, signed or unsigned, through a 3:2 carry-save tree.
- A pipeline register follows each tree level, then a registered final carry-propagate add.
- Valid/ready handshake on both sides with full back-pressure.
- Optional accumulate mode sums multi-beat packets and emits one result per packet.
- Sits between operand-generation logic (partial products, filter taps) and downstream consumers.

Parameters:
- N_OPS, 4, number of operands; must be >= 3.
- WIDTH, 4, bit width of each operand.
- SIGNED, 1, 1 = two's-complement operands (sign-extend MSB); 0 = unsigned (zero-extend).
- ACC_EN, 0, 1 = accumulate beats until in_last; 0 = one result per input beat.
- ACC_GUARD, 4, extra accumulator bits when ACC_EN=1.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_ops  input  N_OPS*WIDTH  packed operands; operand k = in_ops[k*WIDTH +: WIDTH].
- in_last  input  1  last beat of packet; ignored when ACC_EN=0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  RES_W  result. RES_W = OUT_W when ACC_EN=0, else OUT_W+ACC_GUARD. OUT_W = WIDTH+clog2(N_OPS).

Behaviour:
- Reset: out_valid=0 and out_sum=0. All stage valid bits and the accumulator are cleared. in_ready=1 in the cycle after reset deasserts.
- Reset is honoured mid-operation: all in-flight beats and any partial accumulation are discarded with no output.
- Operand extension: each operand is extended to OUT_W bits (sign- or zero-extend per SIGNED) before level 0.
- Arithmetic is exact modulo 2^OUT_W; no overflow is possible for OUT_W.
- Tree:
  - LEVELS = number of 3:2 reductions to go from N_OPS rows to 2 rows, computed by a constant function. N=3→1, 4→2, 6→3, 9→4.
  - Per level, rows are grouped in threes into full-adder rows; 1–2 leftover rows pass through.
  - Carry rows are shifted left 1 and truncated to OUT_W.
- Pipeline: LEVELS register stages, then one CPA stage.
  - Latency from accepted beat to out_valid = LEVELS+1 cycles (3 for defaults) when there is no stall.
  - Throughput is 1 beat/cycle.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - Global stall: stall = out_valid && !out_ready. When stalled, every stage holds and in_ready=0.
  - in_ready = !stall (combinational from out_valid/out_ready).
  - out_sum is stable while out_valid && !out_ready.
  - Bubbles (stage valid=0) propagate; stage data with valid=0 is don't-care.
- Accumulate mode (ACC_EN=1):
  - The CPA result is extended per SIGNED to RES_W and added to acc.
  - On a beat with in_last=1, acc+sum goes to the output register, out_valid=1, and acc clears to 0.
  - Otherwise acc<=acc+sum and no output is produced.
  - in_last travels down the pipe with its beat.
  - The accumulator wraps modulo 2^RES_W.
  - A single-beat packet (in_last on the first beat) equals the non-accumulating result.
- Simultaneous output transfer and new result arrival in the same cycle: the new result loads and out_valid stays 1.

Decomposition:
- Package csa_pkg holds:
  - function clog2;
  - function csa_levels(n);
  - function rows_after(n) = 2*floor(n/3) + n mod 3;
  - typedef-free constants RES_W/OUT_W derivation helpers.
- Sub-module csa_row (parametrised width): one 3:2 full-adder row, producing sum and carry vectors. The tree is built by generate loops instancing csa_row per group per level.

Test Plan:
- Defaults, signed: ops (7,7,7,7) → out_sum = 6'b011100 (28) exactly 3 cycles after acceptance. Ops (-8,-8,-8,-8) → 6'b100000 (-32). Ops (3,-2,5,-1) → 6'b000101.
- SIGNED=0: ops (15,15,15,15) → 6'b111100 (60). N_OPS=9, WIDTH=8, ops all 255 → 12-bit 2295, latency 5.
- Back-pressure: stream 6 beats with out_ready low for cycles 4–7. Required: in_ready=0 while stalled, no beat lost or duplicated, results in order, and out_sum held steady during the stall.
- ACC_EN=1, defaults: beats (1,1,1,1), (2,2,2,2), then last (-1,-1,-1,-1) → a single out_sum = 10'd8. No out_valid on the first two beats; the next packet starts from acc=0.
- Reset mid-stream: assert reset with 2 beats in flight and a partial accumulation. Required: out_valid=0 on the next cycle, no stale result after release, and the next packet sum is correct.
- Random back-to-back beats with random out_ready against a reference model sum, over N_OPS ∈ {3,4,5,7}.
